// File: rtl/data_sync_pkg.sv
// Shared types and default sizing for the data_sync CDC receiver.
package data_sync_pkg;

  // Receiver control states; StVerify is only reachable when the stability check is built in.
  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StVerify = 1'b1
  } ds_state_e;

  localparam int unsigned DS_NUM_STAGES = 2;
  localparam int unsigned DS_BUS_WIDTH  = 8;
  localparam int unsigned DS_CNT_WIDTH  = 8;

endpackage

// File: rtl/data_sync_bit_sync.sv
// bit_sync: NUM_STAGES-deep single-bit synchroniser with asynchronous active-low reset.
module bit_sync #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_STAGES-1:0] sync_q, sync_d;

  // Shift the foreign-domain level one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], d_i};
  end

  // Synchroniser flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// data_sync: multi-bit CDC receiver. BUS_EN is synchronised, its rising edge captures
// UNSYNC_BUS into SYNC_BUS with a one-cycle ENABLE_PULSE and bumps XFER_CNT.
// Optional feature macro DATA_SYNC_STABLE_CHECK_EN adds a verify cycle that re-samples the
// bus and flags BUS_ERR instead of delivering the word when it changed.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DS_NUM_STAGES,
  parameter int unsigned BUS_WIDTH  = DS_BUS_WIDTH,
  parameter int unsigned CNT_WIDTH  = DS_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_EN,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 BUS_ERR,
  output logic [CNT_WIDTH-1:0] XFER_CNT
);

  logic                  en_s;
  logic                  en_d_q, en_d_d;
  logic                  armed_q, armed_d;
  logic [NUM_STAGES-1:0] fill_q, fill_d;
  logic                  edge_det;
  logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
  logic                  pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_en_sync (
    .clk_i (CLK),
    .rst_ni(RST),
    .d_i   (BUS_EN),
    .q_o   (en_s)
  );

  // Arming: the chain's reset zeros are not real samples, so only arm once en_s is known to
  // reflect BUS_EN (fill chain full) and shows it low. An enable already high at reset
  // release therefore never counts as a rising edge.
  always_comb begin
    en_d_d   = en_s;
    fill_d   = {fill_q[NUM_STAGES-2:0], 1'b1};
    armed_d  = armed_q | (fill_q[NUM_STAGES-1] & ~en_s);
    edge_det = en_s & ~en_d_q & armed_q;
  end

  // Edge-detect and arming state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_d_q  <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      en_d_q  <= en_d_d;
      armed_q <= armed_d;
      fill_q  <= fill_d;
    end
  end

`ifdef DATA_SYNC_STABLE_CHECK_EN
  ds_state_e            state_q, state_d;
  logic [BUS_WIDTH-1:0] cap_q, cap_d;
  logic                 err_q, err_d;

  // Capture on the edge, then deliver next cycle only if the bus still matches the shadow copy.
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    err_d      = 1'b0;
    sync_bus_d = sync_bus_q;
    pulse_d    = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (edge_det) begin
          cap_d   = UNSYNC_BUS;
          state_d = StVerify;
        end
      end
      StVerify: begin
        // An edge seen here can only come from a source breaking its timing contract; drop it.
        state_d = StIdle;
        if (UNSYNC_BUS == cap_q) begin
          sync_bus_d = cap_q;
          pulse_d    = 1'b1;
          cnt_d      = cnt_q + CNT_WIDTH'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Verify-path state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
    end
  end

  assign BUS_ERR = err_q;
`else
  // Single-state datapath: the synchronised edge delivers the word directly.
  always_comb begin
    sync_bus_d = sync_bus_q;
    pulse_d    = 1'b0;
    cnt_d      = cnt_q;
    if (edge_det) begin
      sync_bus_d = UNSYNC_BUS;
      pulse_d    = 1'b1;
      cnt_d      = cnt_q + CNT_WIDTH'(1);
    end
  end

  assign BUS_ERR = 1'b0;
`endif

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_bus_q <= '0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_bus_q <= sync_bus_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
    end
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign XFER_CNT     = cnt_q;

endmodule
